// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbiter: operation modes, FSM states
// and the response error classification.
package calc_pkg;

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_MUL = 2'b10;
   localparam logic [1:0] MODE_DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   function automatic logic rsp_is_error(input logic ok, input logic ovf, input logic dz);
      return dz | ovf | ~ok;
   endfunction

endpackage

// File: rtl/calculator.sv
// Combinational 8-bit calculator. The full-precision result is returned on 16 bits;
// ovf_o flags a result outside the 8-bit range of the selected signedness.
module calculator
   import calc_pkg::*;
(
   input  logic [1:0]  mode_i,
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   input  logic        signed_i,
   output logic [15:0] result_o,
   output logic        ok_o,
   output logic        ovf_o,
   output logic        dz_o
);
   logic [15:0] ea_s, eb_s, div_b_s, raw_s;
   logic        dz_s, ovf_s;

   // Extend operands, evaluate the selected operation and classify the result.
   always_comb begin
      ea_s    = signed_i ? {{8{a_i[7]}}, a_i} : {8'h00, a_i};
      eb_s    = signed_i ? {{8{b_i[7]}}, b_i} : {8'h00, b_i};
      dz_s    = (mode_i == MODE_DIV) && (b_i == 8'h00);
      // Keep the divider away from a zero divisor; the result is forced to 0 anyway.
      div_b_s = dz_s ? 16'h0001 : eb_s;
      case (mode_i)
         MODE_ADD: raw_s = ea_s + eb_s;
         MODE_SUB: raw_s = ea_s - eb_s;
         MODE_MUL: raw_s = ea_s * eb_s;
         MODE_DIV: begin
            if (dz_s) begin
               raw_s = 16'h0000;
            end else if (signed_i) begin
               raw_s = $signed(ea_s) / $signed(div_b_s);
            end else begin
               raw_s = ea_s / div_b_s;
            end
         end
         default: raw_s = 16'h0000;
      endcase
      if (dz_s) begin
         ovf_s = 1'b0;
      end else if (signed_i) begin
         ovf_s = (raw_s[15:8] != {8{raw_s[7]}});
      end else begin
         ovf_s = (raw_s[15:8] != 8'h00);
      end
   end

   assign result_o = raw_s;
   assign ok_o     = ~dz_s;
   assign ovf_o    = ovf_s;
   assign dz_o     = dz_s;

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin front end sharing one calculator between two valid/ready requesters;
// the response is held until accepted and completed/errored operations are counted.
module calc_arbiter
   import calc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_mode,
   input  logic [7:0]       req0_a,
   input  logic [7:0]       req0_b,
   input  logic             req0_signed,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_mode,
   input  logic [7:0]       req1_a,
   input  logic [7:0]       req1_b,
   input  logic             req1_signed,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [15:0]      rsp_result,
   output logic             rsp_ok,
   output logic             rsp_ovf,
   output logic             rsp_dz,
   output logic             busy,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] err_count
);
   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [1:0]       mode_q, mode_d;
   logic [7:0]       a_q, a_d, b_q, b_d;
   logic             sgn_q, sgn_d, id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
   logic [15:0]      rsp_result_q, rsp_result_d;
   logic             rsp_ok_q, rsp_ok_d, rsp_ovf_q, rsp_ovf_d, rsp_dz_q, rsp_dz_d;
   logic [CNT_W-1:0] op_count_q, op_count_d, err_count_q, err_count_d;
   logic             grant_s, idle_s;
   logic [15:0]      calc_result_s;
   logic             calc_ok_s, calc_ovf_s, calc_dz_s;

   calculator u_calc (
      .mode_i   (mode_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .signed_i (sgn_q),
      .result_o (calc_result_s),
      .ok_o     (calc_ok_s),
      .ovf_o    (calc_ovf_s),
      .dz_o     (calc_dz_s)
   );

   // A lone requester wins; on a tie the one not served last wins.
   always_comb begin
      if (req0_valid && req1_valid) begin
         grant_s = ~last_grant_q;
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   assign idle_s     = (state_q == ST_IDLE);
   assign req0_ready = idle_s & req0_valid & ~grant_s;
   assign req1_ready = idle_s & req1_valid & grant_s;

   // Next-state: accept in IDLE, sample the calculator in CALC, hand off in RESP.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mode_d       = mode_q;
      a_d          = a_q;
      b_d          = b_q;
      sgn_d        = sgn_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_ok_d     = rsp_ok_q;
      rsp_ovf_d    = rsp_ovf_q;
      rsp_dz_d     = rsp_dz_q;
      op_count_d   = op_count_q;
      err_count_d  = err_count_q;
      case (state_q)
         ST_IDLE: begin
            if (req0_ready || req1_ready) begin
               id_d    = grant_s;
               mode_d  = grant_s ? req1_mode   : req0_mode;
               a_d     = grant_s ? req1_a      : req0_a;
               b_d     = grant_s ? req1_b      : req0_b;
               sgn_d   = grant_s ? req1_signed : req0_signed;
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = id_q;
            rsp_result_d = calc_result_s;
            rsp_ok_d     = calc_ok_s;
            rsp_ovf_d    = calc_ovf_s;
            rsp_dz_d     = calc_dz_s;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d  = 1'b0;
               last_grant_d = rsp_id_q;
               op_count_d   = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (rsp_is_error(rsp_ok_q, rsp_ovf_q, rsp_dz_q) && (err_count_q != {CNT_W{1'b1}})) begin
                  err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  err_count_d = err_count_q;
               end
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registers; reset abandons any operation in flight without responding.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         mode_q       <= 2'b00;
         a_q          <= 8'h00;
         b_q          <= 8'h00;
         sgn_q        <= 1'b0;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= 16'h0000;
         rsp_ok_q     <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         rsp_dz_q     <= 1'b0;
         op_count_q   <= {CNT_W{1'b0}};
         err_count_q  <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mode_q       <= mode_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sgn_q        <= sgn_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_ok_q     <= rsp_ok_d;
         rsp_ovf_q    <= rsp_ovf_d;
         rsp_dz_q     <= rsp_dz_d;
         op_count_q   <= op_count_d;
         err_count_q  <= err_count_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_ok     = rsp_ok_q;
   assign rsp_ovf    = rsp_ovf_q;
   assign rsp_dz     = rsp_dz_q;
   assign busy       = ~idle_s;
   assign op_count   = op_count_q;
   assign err_count  = err_count_q;

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
- Shares one combinational `calculator` instance between two requesters.
- Each requester uses a valid/ready handshake; grants are round-robin.
- Accepted operands are registered, the calculator output is sampled, and the response is held until accepted.
- Keeps running operation and error counters for status/debug. Sits between requester blocks and the calculator datapath.

Parameters:
- CNT_W, 16, width of op_count and err_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_mode  in  2  00 add, 01 sub, 10 mul, 11 div.
- req0_a  in  8  operand A.
- req0_b  in  8  operand B.
- req0_signed  in  1  1 = two's-complement operation.
- req1_valid, req1_ready, req1_mode, req1_a, req1_b, req1_signed: same as requester 0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  16  calculator result.
- rsp_ok  out  1  calculator valid flag.
- rsp_ovf  out  1  calculator overflow flag.
- rsp_dz  out  1  calculator divide_by_zero flag.
- busy  out  1  state != IDLE.
- op_count  out  CNT_W  completed responses; wraps.
- err_count  out  CNT_W  responses with rsp_dz | rsp_ovf | !rsp_ok; saturates at all-ones.

Behaviour:
- Reset:
  - state=IDLE, last_grant=1 (so req0 wins the first tie).
  - All registered outputs 0: rsp_*, op_count, err_count.
  - Operand registers cleared; busy=0.
  - Reset in any state aborts the operation and discards it; no response is issued.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - grant = the only valid requester; if both valid, the one != last_grant.
  - reqN_ready is combinational: 1 only for the granted requester while in IDLE. No valid → no ready.
  - On valid&ready at an edge: latch mode/a/b/signed and id into registers → CALC.
- CALC:
  - Calculator inputs come only from the latched registers.
  - At the edge: capture result and flags into the rsp_* registers, set rsp_valid=1 → RESP.
- RESP:
  - rsp_* held stable; both req_ready=0.
  - On rsp_valid&rsp_ready at an edge:
    - rsp_valid←0, last_grant←rsp_id, op_count+1.
    - err_count+1 if error and not saturated.
    - → IDLE.
  - rsp_ready low holds RESP indefinitely.
- Latency and throughput:
  - Accept at edge t → rsp_valid high after edge t+1.
  - Earliest next accept is the cycle after the response handshake, i.e. one op per 3 cycles.
- Requesters must hold valid and operands stable until ready. Deasserting valid before grant is legal; nothing is latched.
- Divide-by-zero and invalid results are returned normally with flags; they are never dropped.
- op_count wraps from all-ones to 0.
- rsp_ready asserted outside RESP is ignored.

Decomposition:
- Shared package `calc_pkg`:
  - mode localparams MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_MUL=2'b10, MODE_DIV=2'b11.
  - FSM state encodings ST_IDLE, ST_CALC, ST_RESP.
- One sub-module: the existing `calculator`, instantiated once as the shared datapath.
- Arbitration and counters stay inline.

Test Plan:
1. req0 mode=00 a=05 b=03 signed=0, rsp_ready=1 → req0_ready 1 cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_result=0008, rsp_ok=1; op_count=1.
2. req1 mode=01 a=FE b=01 signed=1 → rsp_id=1, rsp_result=FFFD, rsp_ovf=0; err_count unchanged.
3. req0 mode=11 a=10 b=00 → rsp_dz=1 and the response is still delivered; err_count increments by 1.
4. Both valid continuously for 4 ops → grants in order 0,1,0,1; each ready pulse lasts one cycle, never both in one cycle.
5. rsp_ready low 5 cycles in RESP → rsp_* stable, both ready=0, busy=1; on rsp_ready=1 → IDLE, op_count+1.
6. Assert rst during CALC, and separately during RESP → next cycle state IDLE, rsp_valid=0, counters 0, no response delivered; a following req0 5+3 yields 0008 with rsp_id=0.
